// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, the instruction memory, the redirect source and decode.
// The master modport is the fetch_unit side; the slave modport is the surrounding pipeline/memory.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 32
);
  logic                   imem_req;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   redirect;
  logic [ADDR_WIDTH-1:0]  redirect_pc;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [INSTR_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0]  instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, credit-limited requests to a 1-cycle memory, and a fetch buffer.
// Optional macro FETCH_PERF_EN adds pop / flush performance counters.

// Safety checker: the credit scheme must never let a return land in a full buffer.
module fetch_unit_chk #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input logic             i_clk,
  input logic             i_rst,
  input logic             i_push,
  input logic [CNT_W-1:0] i_count
);
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && (i_count >= CNT_W'(FIFO_DEPTH))));
endmodule

module fetch_unit #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    FIFO_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = {ADDR_WIDTH{1'b0}}
) (
  input  logic          i_clk,
  input  logic          i_rst,
  fetch_unit_if.master  io_bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   o_perf_fetched,
  output logic [31:0]   o_perf_flushes
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] PC_ALIGN = ~ADDR_WIDTH'(3);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [ADDR_WIDTH-1:0]  r_req_pc;
  logic                   r_inflight;
  logic [CNT_W-1:0]       r_count;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [INSTR_WIDTH-1:0] r_mem_instr [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  r_mem_pc    [FIFO_DEPTH];

  logic                   w_req;
  logic                   w_push;
  logic                   w_pop;
  logic [CNT_W-1:0]       w_count_nxt;
  logic [CNT_W-1:0]       w_occ_nxt;

  // Handshake decode, buffer occupancy and next-state selection
  always_comb begin
    w_state_nxt = r_state;
    w_push      = r_inflight & ~io_bus.redirect;
    w_pop       = (r_count != {CNT_W{1'b0}}) & io_bus.instr_ready & ~io_bus.redirect;
    w_req       = (r_state == ST_FETCH) & ~io_bus.redirect;
    w_count_nxt = r_count;

    if (io_bus.redirect) begin
      w_count_nxt = {CNT_W{1'b0}};
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
    end

    // Credit = buffered entries plus the word still coming back from memory
    w_occ_nxt = w_count_nxt + CNT_W'(w_req);

    case (r_state)
      ST_START: w_state_nxt = ST_FETCH;
      ST_FETCH, ST_STALL: begin
        if (io_bus.redirect) begin
          w_state_nxt = ST_FETCH;
        end else if (w_occ_nxt >= CNT_W'(FIFO_DEPTH)) begin
          w_state_nxt = ST_STALL;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_START;
    endcase
  end

  // State, PC, in-flight tracking and buffer pointers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_START;
      r_pc       <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_inflight <= 1'b0;
      r_count    <= {CNT_W{1'b0}};
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_req;
      r_count    <= w_count_nxt;
      if (w_req) begin
        r_req_pc <= r_pc;
      end
      if (io_bus.redirect) begin
        r_pc     <= io_bus.redirect_pc & PC_ALIGN;
        r_wr_ptr <= {PTR_W{1'b0}};
        r_rd_ptr <= {PTR_W{1'b0}};
      end else begin
        if (w_req) begin
          r_pc <= r_pc + PC_STEP;
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  // Buffer storage; contents are meaningless while count is zero
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= io_bus.imem_rdata;
      r_mem_pc[r_wr_ptr]    <= r_req_pc;
    end
  end

  assign io_bus.imem_req    = w_req;
  assign io_bus.imem_addr   = r_pc;
  assign io_bus.instr_valid = (r_count != {CNT_W{1'b0}});
  assign io_bus.instr       = r_mem_instr[r_rd_ptr];
  assign io_bus.instr_pc    = r_mem_pc[r_rd_ptr];

`ifdef FETCH_PERF_EN
  // Pops void during a redirect are excluded because w_pop already masks them
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_perf_fetched <= 32'd0;
      o_perf_flushes <= 32'd0;
    end else begin
      if (w_pop) begin
        o_perf_fetched <= o_perf_fetched + 32'd1;
      end
      if (io_bus.redirect) begin
        o_perf_flushes <= o_perf_flushes + 32'd1;
      end
    end
  end
`endif

  fetch_unit_chk #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_chk (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_count (r_count)
  );
endmodule
